// File: rtl/stash_scan_table_nz_if.sv
// ---------------------------------------------------------------------------
// stash_scan_table_nz_if
//
// Bundles the scan request/response, the current-path qualifier, the
// writeback (DMA) ready/valid stream and the ResetDone status of the
// Path ORAM placement table.
//
// Modports:
//   slave  - the placement table (consumes scans / DMAStart, produces
//            results and the writeback stream)
//   master - the controller driving scans and consuming the stream
//
// Signals:
//   ResetDone                 table swept and idle
//   CurrentLeaf / Valid       leaf of the path being written back
//   InScanLeaf/SAddr/Valid    scan request
//   OutScanValid/Accepted/SAddr/Level  registered scan result
//   DMAStart                  pulse, starts the writeback drain
//   OutDMAAddr/Valid/Ready/Last        writeback stream
// ---------------------------------------------------------------------------
interface stash_scan_table_nz_if #(
    parameter int ORAML    = 16,
    parameter int SEAWidth = 8,
    parameter int LvlWidth = $clog2(ORAML + 1)
);
    logic                ResetDone;
    logic [ORAML-1:0]    CurrentLeaf;
    logic                CurrentLeafValid;
    logic [ORAML-1:0]    InScanLeaf;
    logic [SEAWidth-1:0] InScanSAddr;
    logic                InScanValid;
    logic                OutScanValid;
    logic                OutScanAccepted;
    logic [SEAWidth-1:0] OutScanSAddr;
    logic [LvlWidth-1:0] OutScanLevel;
    logic                DMAStart;
    logic [SEAWidth-1:0] OutDMAAddr;
    logic                OutDMAValid;
    logic                OutDMAReady;
    logic                OutDMALast;

    modport slave (
        input  CurrentLeaf, CurrentLeafValid,
        input  InScanLeaf, InScanSAddr, InScanValid,
        input  DMAStart, OutDMAReady,
        output ResetDone,
        output OutScanValid, OutScanAccepted, OutScanSAddr, OutScanLevel,
        output OutDMAAddr, OutDMAValid, OutDMALast
    );

    modport master (
        output CurrentLeaf, CurrentLeafValid,
        output InScanLeaf, InScanSAddr, InScanValid,
        output DMAStart, OutDMAReady,
        input  ResetDone,
        input  OutScanValid, OutScanAccepted, OutScanSAddr, OutScanLevel,
        input  OutDMAAddr, OutDMAValid, OutDMALast
    );
endinterface

// File: rtl/stash_scan_table_nz.sv
// ---------------------------------------------------------------------------
// stash_scan_table_nz
//
// Path ORAM eviction placement table with a leaf bucket size (ZLeaf) that
// may differ from the interior bucket size (ORAMZ). Each scanned stash entry
// is placed in the deepest bucket on the current path that is both legal
// and not full, or rejected. A DMAStart drains the table, root bucket first,
// as a ready/valid stream of stash addresses (SNULL for empty slots).
//
// Ports:
//   Clock           rising-edge clock
//   Reset           synchronous active-high full reset (starts a sweep)
//   PerAccessReset  synchronous; clears counters, aborts a drain, sweeps
//   bus (slave)     scan / writeback / ResetDone signals, see the interface
//   OutRejectCount  [15:0] saturating count of rejected scan results,
//                   present only when STASH_SCAN_STATS_EN is defined
//
// Optional feature macro: STASH_SCAN_STATS_EN
// ---------------------------------------------------------------------------
module stash_scan_table_nz #(
    parameter int ORAML    = 16,
    parameter int ORAMZ    = 4,
    parameter int ZLeaf    = 4,
    parameter int SEAWidth = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic PerAccessReset,
    stash_scan_table_nz_if.slave bus
`ifdef STASH_SCAN_STATS_EN
    ,
    output logic [15:0] OutRejectCount
`endif
);
    localparam int BlocksOnPath = ORAML * ORAMZ + ZLeaf;
    localparam int STAWidth     = (BlocksOnPath > 1) ? $clog2(BlocksOnPath) : 1;
    localparam int LvlWidth     = $clog2(ORAML + 1);
    localparam int IdxWidth     = $clog2(BlocksOnPath + 1);
    localparam logic [SEAWidth-1:0] SNULL    = {SEAWidth{1'b1}};
    localparam logic [STAWidth-1:0] LastSlot = STAWidth'(BlocksOnPath - 1);

    typedef enum logic [1:0] {
        ST_SWEEP,
        ST_SCAN,
        ST_DRAIN
    } state_t;

    state_t state_q, state_d;

    // Sweep and drain read pointers
    logic [STAWidth-1:0] sweep_idx_q, sweep_idx_d;
    logic [IdxWidth-1:0] rd_idx_q, rd_idx_d;
    // A read issued last cycle whose data is now in mem_rd_q
    logic                rd_pend_q, rd_pend_d;
    logic                rd_last_q, rd_last_d;

    // Two-entry skid buffer, entry 0 is the head
    logic [SEAWidth-1:0] fifo_data_q [2];
    logic [SEAWidth-1:0] fifo_data_d [2];
    logic [1:0]          fifo_last_q, fifo_last_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [1:0]          occ_after_pop;
    logic                dma_valid, dma_pop, dma_push;

    // Registered scan result
    logic                out_scan_valid_q, out_scan_valid_d;
    logic                out_scan_accepted_q, out_scan_accepted_d;
    logic [SEAWidth-1:0] out_scan_saddr_q, out_scan_saddr_d;
    logic [LvlWidth-1:0] out_scan_level_q, out_scan_level_d;

    // Table RAM: one write port, one registered read port
    logic [SEAWidth-1:0] table_mem [BlocksOnPath];
    logic                mem_we, mem_re;
    logic [STAWidth-1:0] mem_waddr, mem_raddr;
    logic [SEAWidth-1:0] mem_wdata;
    logic [SEAWidth-1:0] mem_rd_q;

    // Placement
    logic [ORAML-1:0]    leaf_diff;
    logic [LvlWidth-1:0] legal_depth;
    logic                place_found;
    logic [LvlWidth-1:0] place_lvl;
    logic [STAWidth-1:0] place_slot;
    logic                scan_fire, place_en;
    logic [ORAML:0]      lvl_free;
    logic [STAWidth-1:0] lvl_slot [ORAML+1];

    // -----------------------------------------------------------------------
    // Per-level occupancy counters; each is just wide enough for its bucket
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi <= ORAML; gi++) begin : g_lvl
            localparam int Cap = (gi == ORAML) ? ZLeaf : ORAMZ;
            localparam int CW  = $clog2(Cap + 1);

            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (PerAccessReset) begin
                    cnt_d = '0;
                end else if (place_en && (place_lvl == LvlWidth'(gi))) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign lvl_free[gi] = (cnt_q < CW'(Cap));
            // Next free slot of this bucket; buckets are laid out ORAMZ apart
            assign lvl_slot[gi] = STAWidth'(gi * ORAMZ) + STAWidth'(cnt_q);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Placement: deepest non-full level not below the divergence point
    // -----------------------------------------------------------------------
    always_comb begin
        leaf_diff   = bus.CurrentLeaf ^ bus.InScanLeaf;
        // Trailing-zero count; equal leaves share the whole path
        legal_depth = LvlWidth'(ORAML);
        for (int i = ORAML - 1; i >= 0; i--) begin
            if (leaf_diff[i]) begin
                legal_depth = LvlWidth'(i);
            end
        end

        place_found = 1'b0;
        place_lvl   = '0;
        place_slot  = '0;
        // Ascending scan so the last hit is the deepest candidate
        for (int l = 0; l <= ORAML; l++) begin
            if ((LvlWidth'(l) <= legal_depth) && lvl_free[l]) begin
                place_found = 1'b1;
                place_lvl   = LvlWidth'(l);
                place_slot  = lvl_slot[l];
            end
        end

        scan_fire = (state_q == ST_SCAN) && bus.InScanValid && !PerAccessReset;
        place_en  = scan_fire && place_found && bus.CurrentLeafValid;
    end

    always_comb begin
        out_scan_valid_d    = scan_fire;
        out_scan_accepted_d = place_en;
        out_scan_saddr_d    = out_scan_saddr_q;
        out_scan_level_d    = out_scan_level_q;
        if (scan_fire) begin
            out_scan_saddr_d = bus.InScanSAddr;
            out_scan_level_d = place_en ? place_lvl : '0;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM, RAM port muxing and skid buffer
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        sweep_idx_d   = sweep_idx_q;
        rd_idx_d      = rd_idx_q;
        rd_pend_d     = 1'b0;
        rd_last_d     = 1'b0;
        fifo_data_d   = fifo_data_q;
        fifo_last_d   = fifo_last_q;
        mem_we        = 1'b0;
        mem_waddr     = sweep_idx_q;
        mem_wdata     = SNULL;
        mem_re        = 1'b0;
        mem_raddr     = '0;

        dma_pop       = dma_valid && bus.OutDMAReady;
        dma_push      = rd_pend_q;
        occ_after_pop = fifo_cnt_q - {1'b0, dma_pop};

        if (dma_pop) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
        end
        if (dma_push) begin
            if (occ_after_pop == 2'd0) begin
                fifo_data_d[0] = mem_rd_q;
                fifo_last_d[0] = rd_last_q;
            end else begin
                fifo_data_d[1] = mem_rd_q;
                fifo_last_d[1] = rd_last_q;
            end
        end
        fifo_cnt_d = occ_after_pop + {1'b0, dma_push};

        case (state_q)
            ST_SWEEP: begin
                mem_we = 1'b1;
                if (sweep_idx_q == LastSlot) begin
                    state_d     = ST_SCAN;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            ST_SCAN: begin
                if (place_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = place_slot;
                    mem_wdata = bus.InScanSAddr;
                end
                // Slot 0 is read on the start edge so the first word is
                // presented two cycles after DMAStart
                if (bus.DMAStart) begin
                    state_d   = ST_DRAIN;
                    mem_re    = 1'b1;
                    mem_raddr = '0;
                    rd_pend_d = 1'b1;
                    rd_last_d = (BlocksOnPath == 1);
                    rd_idx_d  = IdxWidth'(1);
                end
            end
            ST_DRAIN: begin
                // Read ahead only if the word can land in the skid buffer
                if ((rd_idx_q < IdxWidth'(BlocksOnPath)) && (fifo_cnt_d <= 2'd1)) begin
                    mem_re    = 1'b1;
                    mem_raddr = rd_idx_q[STAWidth-1:0];
                    rd_pend_d = 1'b1;
                    rd_last_d = (rd_idx_q[STAWidth-1:0] == LastSlot);
                    rd_idx_d  = rd_idx_q + 1'b1;
                end
                if (dma_pop && fifo_last_q[0]) begin
                    state_d    = ST_SCAN;
                    fifo_cnt_d = '0;
                    rd_pend_d  = 1'b0;
                    rd_idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_SWEEP;
            end
        endcase

        if (PerAccessReset) begin
            state_d     = ST_SWEEP;
            sweep_idx_d = '0;
            rd_idx_d    = '0;
            rd_pend_d   = 1'b0;
            rd_last_d   = 1'b0;
            fifo_cnt_d  = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q             <= ST_SWEEP;
            sweep_idx_q         <= '0;
            rd_idx_q            <= '0;
            rd_pend_q           <= 1'b0;
            rd_last_q           <= 1'b0;
            fifo_data_q[0]      <= SNULL;
            fifo_data_q[1]      <= SNULL;
            fifo_last_q         <= '0;
            fifo_cnt_q          <= '0;
            out_scan_valid_q    <= 1'b0;
            out_scan_accepted_q <= 1'b0;
            out_scan_saddr_q    <= '0;
            out_scan_level_q    <= '0;
        end else begin
            state_q             <= state_d;
            sweep_idx_q         <= sweep_idx_d;
            rd_idx_q            <= rd_idx_d;
            rd_pend_q           <= rd_pend_d;
            rd_last_q           <= rd_last_d;
            fifo_data_q         <= fifo_data_d;
            fifo_last_q         <= fifo_last_d;
            fifo_cnt_q          <= fifo_cnt_d;
            out_scan_valid_q    <= out_scan_valid_d;
            out_scan_accepted_q <= out_scan_accepted_d;
            out_scan_saddr_q    <= out_scan_saddr_d;
            out_scan_level_q    <= out_scan_level_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            table_mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rd_q <= table_mem[mem_raddr];
        end
    end

    assign dma_valid           = (state_q == ST_DRAIN) && (fifo_cnt_q != 2'd0);
    assign bus.OutDMAValid     = dma_valid;
    assign bus.OutDMAAddr      = dma_valid ? fifo_data_q[0] : SNULL;
    assign bus.OutDMALast      = dma_valid && fifo_last_q[0];
    assign bus.ResetDone       = (state_q == ST_SCAN);
    assign bus.OutScanValid    = out_scan_valid_q;
    assign bus.OutScanAccepted = out_scan_accepted_q;
    assign bus.OutScanSAddr    = out_scan_saddr_q;
    assign bus.OutScanLevel    = out_scan_level_q;

`ifdef STASH_SCAN_STATS_EN
    logic [15:0] reject_cnt_q, reject_cnt_d;

    always_comb begin
        reject_cnt_d = reject_cnt_q;
        if (out_scan_valid_q && !out_scan_accepted_q && (reject_cnt_q != 16'hFFFF)) begin
            reject_cnt_d = reject_cnt_q + 16'd1;
        end
        if (PerAccessReset) begin
            reject_cnt_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            reject_cnt_q <= '0;
        end else begin
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign OutRejectCount = reject_cnt_q;
`endif
endmodule

// File: doc/stash_scan_table_nz.md
# stash_scan_table_nz

Per-access placement table for Path ORAM eviction, generalised to a leaf bucket size that can differ from the interior bucket size. For each stash entry scanned, it places the block in the deepest bucket on the current path that is both legal and not full, or rejects it. After the scan it streams the chosen stash addresses, root bucket first, to the path-writeback engine. Successor to the fixed-Z scan table: it generates writeback addresses internally, drives a ready/valid writeback stream with a last flag, and can abort on per-access reset.

## Interface
Parameters:
- ORAML, 16, tree depth; levels 0 (root) … ORAML (leaf).
- ORAMZ, 4, slots per interior bucket (levels 0…ORAML-1).
- ZLeaf, 4, slots per leaf bucket (level ORAML); must be ≥1.
- SEAWidth, 8, stash entry address width; SNULL = all ones.
- Derived constants:
  - BlocksOnPath = ORAML·ORAMZ + ZLeaf.
  - STAWidth = log2(BlocksOnPath).
  - LvlWidth = log2(ORAML+1).

Ports (clock and reset first):
- Clock  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high; full reset plus table sweep.
- PerAccessReset  in  1  synchronous; clears counters, aborts any drain, starts a sweep.
- ResetDone  out  1  high when the table is swept and the block is idle.
- CurrentLeaf  in  ORAML  leaf of the path being written back.
- CurrentLeafValid  in  1  CurrentLeaf is valid.
- InScanLeaf  in  ORAML  leaf of the scanned block.
- InScanSAddr  in  SEAWidth  stash address of the scanned block.
- InScanValid  in  1  scan request.
- OutScanValid  out  1  scan result valid.
- OutScanAccepted  out  1  block was placed.
- OutScanSAddr  out  SEAWidth  echo of InScanSAddr.
- OutScanLevel  out  LvlWidth  level where the block was placed; 0 when rejected.
- DMAStart  in  1  pulse; begins the writeback drain.
- OutDMAAddr  out  SEAWidth  stash address, or SNULL for a dummy slot.
- OutDMAValid  out  1  OutDMAAddr is valid.
- OutDMAReady  in  1  consumer accepts the current word.
- OutDMALast  out  1  marks the word for slot BlocksOnPath-1.

## Operation
States:
- SWEEP: entered on Reset or PerAccessReset.
  - Writes SNULL to slots 0…BlocksOnPath-1, one slot per cycle, so BlocksOnPath cycles.
  - Then moves to SCAN.
- SCAN: ResetDone=1.
  - Accepts one scan per cycle.
  - DMAStart moves the block to DRAIN.
- DRAIN: ResetDone=0.
  - Reads slots 0…BlocksOnPath-1 in order and drives them out on the writeback stream.
  - After the Last word handshakes, returns to SCAN. Table contents are kept.
- PerAccessReset overrides every state and has priority over a same-cycle DMAStart or scan.

Placement rules:
- Leaf bit i (LSB first) selects the branch taken at level i+1.
- Legal depth k = number of trailing zeros of (CurrentLeaf XOR InScanLeaf); k = ORAML when the two leaves are equal.
- Capacity: cap(l) = ORAMZ for l < ORAML; cap(ORAML) = ZLeaf.
- Choose the largest l ≤ k with cnt[l] < cap(l).
- Accept only if such an l exists and CurrentLeafValid=1. Otherwise reject.
- On accept:
  - Write InScanSAddr to slot l·ORAMZ + cnt[l].
  - Increment cnt[l] at the same edge.
- Width rules:
  - Each cnt[l] is log2(cap(l)+1) bits and never exceeds cap(l).
  - Slot address arithmetic is done in STAWidth bits.
- Inputs are dropped: InScanValid outside SCAN produces no OutScanValid and no table write; DMAStart outside SCAN is ignored.

Writeback stream:
- The RAM has 1-cycle read latency. A 2-entry skid buffer holds read data, so read-ahead never loses a word.
- OutDMAValid stays asserted until OutDMAReady.
- OutDMAAddr and OutDMALast stay stable while Valid=1 and Ready=0.

## Timing
- Reset values: ResetDone=0, OutScanValid=0, OutScanAccepted=0, OutScanSAddr=0, OutScanLevel=0, OutDMAValid=0, OutDMALast=0, OutDMAAddr=SNULL, all cnt[l]=0.
- ResetDone rises BlocksOnPath+1 cycles after the reset cycle.
- Scan latency is 1 cycle: outputs are registered. Back-to-back scans see updated counts with no bubble.
- First OutDMAValid appears 2 cycles after DMAStart.
- Full-rate drain (Ready held at 1) takes BlocksOnPath consecutive Valid cycles.
- ResetDone returns to 1 the cycle after the Last handshake.
- PerAccessReset during DRAIN: OutDMAValid=0 on the next cycle and the skid buffer is flushed. A sweep then follows.

## Configuration
- STASH_SCAN_STATS_EN defined:
  - Adds output OutRejectCount [15:0].
  - Counts cycles with OutScanValid=1 and OutScanAccepted=0; saturates at 16'hFFFF.
  - Cleared by Reset or PerAccessReset.
- Not defined: the port and the counter do not exist.

## Test plan
Bench configuration for all scenarios: ORAML=3, ORAMZ=2, ZLeaf=3, SEAWidth=8, so BlocksOnPath=9.
- Reset, then drain with Ready=1 -> ResetDone rises at cycle 10; drain outputs 9 words, all 8'hFF; Last on the 9th word only.
- CurrentLeaf=3'b101; scan four blocks with leaf 3'b101, SAddr 1…4 -> levels 3,3,3,2; slots 6,7,8,4 hold 1,2,3,4.
- CurrentLeaf=3'b000; scan leaf 3'b001 five times -> first two accepted at level 0; next three rejected (OutScanLevel=0); with STASH_SCAN_STATS_EN, OutRejectCount=3.
- Drain with Ready toggling 1,0,0,1… -> no word dropped or duplicated; OutDMAAddr is stable while stalled; order is slot 0…8.
- Assert PerAccessReset on the 4th drain word -> OutDMAValid=0 on the next cycle; sweep runs; a fresh drain returns all SNULL.
- Scans while ResetDone=0, and CurrentLeafValid=0 in SCAN -> no result and no write during the sweep; in SCAN, result valid with Accepted=0; all cnt[l] unchanged.
